trace_buffer: RTL

Parametrised trace back-end for the Ryuki core trace path. Owns the free-running cycle counter that the stage trackers use as their timestamp source, and accepts completed per-instruction trace records from the writeback tracker. Stores the records in a DEPTH-entry FIFO and drains them to a downstream sink over a valid/ready handshake. When the FIFO is full, it drops records, counts them and, optionally, reports them.

---
 rtl/trace_buffer_pkg.sv | 29 ++
 rtl/trace_buffer_fifo.sv | 54 +++++
 rtl/trace_buffer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/trace_buffer_pkg.sv
// ryuki_datatypes: shared types for the Ryuki trace path.
//   trace_buffer_state_t - drop/marker FSM encoding used by trace_buffer.
//   trace_entry_bits()   - packed width of one trace_entry_t for given widths.
// Optional feature macro: TRACE_BUFFER_MARKER_EN (adds the MARKER_PEND state).
package ryuki_datatypes;

`ifdef TRACE_BUFFER_MARKER_EN
    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        DROPPING    = 2'd1,
        MARKER_PEND = 2'd2
    } trace_buffer_state_t;
`else
    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DROPPING = 2'd1
    } trace_buffer_state_t;
`endif

    // trace_entry_t = {is_marker, addr, instr, start, end}; its field widths
    // follow the owning module's parameters, so the typedef itself lives in
    // trace_buffer and this helper gives its packed width.
    function automatic int unsigned trace_entry_bits(input int unsigned addr_w,
                                                     input int unsigned data_w,
                                                     input int unsigned count_w);
        return 1 + addr_w + data_w + 2 * count_w;
    endfunction

endpackage

// File: rtl/trace_buffer_fifo.sv
// trace_fifo: generic DEPTH x WIDTH storage FIFO with a combinational head.
//   clk, rst      - clock, asynchronous active-high reset (pointers only)
//   push, din     - write din at the tail
//   pop           - retire the head
//   dout          - current head entry (valid when !empty)
//   full, empty   - status; pointers carry one extra wrap bit to tell them apart
//   count         - occupied entries, 0..DEPTH
// The caller must not push while full unless it pops in the same cycle.
module trace_fifo
    import ryuki_datatypes::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Push into a full FIFO with a concurrent pop writes the slot the head
    // is leaving; the head is read before the edge, so no data is lost.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: Ryuki trace back-end.
//   Owns the free-running cycle counter (cycle_count_o) used as timestamp
//   source, buffers completed trace records (rec_*) in a DEPTH-entry FIFO and
//   drains them over out_valid/out_ready. Records captured while the FIFO
//   cannot accept them are dropped and counted in dropped_total (saturating).
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   trace_en           - capture enable for rec_valid
//   cycle_count_o      - cycle counter, wraps mod 2^COUNT_WIDTH
//   rec_valid, rec_*   - one completed record per pulse
//   out_valid/out_ready- head handshake; out_* hold while stalled
//   out_is_marker      - head is an overflow marker (out_instr = drop count)
//   fill_level         - occupied FIFO entries
//   dropped_total      - lifetime drop count, saturating
// Optional macro TRACE_BUFFER_MARKER_EN: emit overflow marker entries after a
// drop burst. Without it drops are only counted and out_is_marker is 0.
module trace_buffer
    import ryuki_datatypes::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DROP_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    output logic [COUNT_WIDTH-1:0]   cycle_count_o,
    input  logic                     rec_valid,
    input  logic [ADDR_WIDTH-1:0]    rec_addr,
    input  logic [DATA_WIDTH-1:0]    rec_instr,
    input  logic [COUNT_WIDTH-1:0]   rec_start,
    input  logic [COUNT_WIDTH-1:0]   rec_end,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_is_marker,
    output logic [ADDR_WIDTH-1:0]    out_addr,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [COUNT_WIDTH-1:0]   out_start,
    output logic [COUNT_WIDTH-1:0]   out_end,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [DROP_WIDTH-1:0]    dropped_total
);

    typedef struct packed {
        logic                   is_marker;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0]  instr;
        logic [COUNT_WIDTH-1:0] start_ts;
        logic [COUNT_WIDTH-1:0] end_ts;
    } trace_entry_t;

    localparam int unsigned EW = trace_entry_bits(ADDR_WIDTH, DATA_WIDTH, COUNT_WIDTH);

    logic [COUNT_WIDTH-1:0] cycle_q;
    trace_buffer_state_t    state_q, state_d;
    logic [DROP_WIDTH-1:0]  pend_q, pend_d, pend_inc;
    logic [DROP_WIDTH-1:0]  drop_total_q;

    logic         capture, pop, can_push, push, drop;
    logic         fifo_full, fifo_empty;
    trace_entry_t rec_entry, fifo_din, head;
    logic [EW-1:0] fifo_dout;

    // ---------------- cycle counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_q <= '0;
        else     cycle_q <= cycle_q + COUNT_WIDTH'(1);
    end
    assign cycle_count_o = cycle_q;

    // ---------------- acceptance ----------------
    assign capture  = rec_valid && trace_en;
    assign pop      = !fifo_empty && out_ready;
    assign can_push = !fifo_full || pop;
    assign pend_inc = (pend_q == '1) ? pend_q : pend_q + DROP_WIDTH'(1);

    always_comb begin
        rec_entry           = '0;
        rec_entry.addr      = rec_addr;
        rec_entry.instr     = rec_instr;
        rec_entry.start_ts  = rec_start;
        rec_entry.end_ts    = rec_end;
    end

    // ---------------- drop / marker FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= NORMAL;
            pend_q       <= '0;
            drop_total_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (drop && drop_total_q != '1)
                drop_total_q <= drop_total_q + DROP_WIDTH'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        push     = 1'b0;
        drop     = 1'b0;
        fifo_din = rec_entry;
        unique case (state_q)
            NORMAL: begin
                if (capture) begin
                    if (can_push) begin
                        push = 1'b1;
                    end else begin
                        drop    = 1'b1;
                        pend_d  = DROP_WIDTH'(1);
                        state_d = DROPPING;
                    end
                end
            end
            DROPPING: begin
`ifdef TRACE_BUFFER_MARKER_EN
                // The marker owns the next free slot, so captures here are
                // dropped even when a slot opens this cycle.
                if (capture) begin
                    drop   = 1'b1;
                    pend_d = pend_inc;
                end
                if (can_push) state_d = MARKER_PEND;
`else
                if (can_push) begin
                    state_d = NORMAL;
                    pend_d  = '0;
                    push    = capture;
                end else if (capture) begin
                    drop   = 1'b1;
                    pend_d = pend_inc;
                end
`endif
            end
`ifdef TRACE_BUFFER_MARKER_EN
            MARKER_PEND: begin
                if (can_push) begin
                    push               = 1'b1;
                    fifo_din           = '0;
                    fifo_din.is_marker = 1'b1;
                    fifo_din.instr     = DATA_WIDTH'(pend_q);
                    fifo_din.start_ts  = cycle_q;
                    fifo_din.end_ts    = cycle_q;
                    state_d            = NORMAL;
                    pend_d             = '0;
                    if (capture) begin
                        drop    = 1'b1;
                        pend_d  = DROP_WIDTH'(1);
                        state_d = DROPPING;
                    end
                end else if (capture) begin
                    drop   = 1'b1;
                    pend_d = pend_inc;
                end
            end
`endif
            default: begin
                state_d = NORMAL;
                pend_d  = '0;
            end
        endcase
    end

    // ---------------- storage ----------------
    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_level)
    );

    // Head fields are forced to zero while empty so that the outputs show
    // their reset values immediately on rst, regardless of RAM contents.
    assign head      = fifo_dout;
    assign out_valid = !fifo_empty;
    assign out_addr  = out_valid ? head.addr     : '0;
    assign out_instr = out_valid ? head.instr    : '0;
    assign out_start = out_valid ? head.start_ts : '0;
    assign out_end   = out_valid ? head.end_ts   : '0;

`ifdef TRACE_BUFFER_MARKER_EN
    assign out_is_marker = out_valid && head.is_marker;
`else
    logic head_marker_unused;
    assign head_marker_unused = head.is_marker;
    assign out_is_marker      = 1'b0;
`endif

    assign dropped_total = drop_total_q;

endmodule
